clkratio_det: RTL and testbench

Clock-ratio detector for the CPU clock-switching path: samples a divided clock (/2 or /4 of `clkin`, 50:50 duty) as data in the `clkin` domain, measures its period and high-phase width, and reports a locked ratio. It is the receiving end of the divide-by-2/4 generator. Its outputs let the cycle-stretch and bus-timing logic confirm which ratio is active before using it, and flag a stopped or corrupted divided clock.

---
 rtl/clkratio_det.sv | 146 ++++++++++++++
 tb/tb_clkratio_det.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/clkratio_det.sv
// Measures a /2 or /4 divided clock sampled in the clkin domain and reports a locked, symmetric ratio.
// Outputs registered, 2 clkin edges after a divclk level is first captured; no backpressure.
module clkratio_det #(
  parameter int CNT_W      = 4,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clkin,
  input  logic             rstb,
  input  logic             divclk,
  output logic [CNT_W-1:0] period,
  output logic             div4not2,
  output logic             locked,
  output logic             err
);

  localparam logic [CNT_W-1:0] MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] P2     = CNT_W'(2);
  localparam logic [CNT_W-1:0] P4     = CNT_W'(4);
  localparam logic [3:0]       LOCK_M = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {ST_SEED, ST_HUNT, ST_LOCKED} state_t;

  state_t           state, state_nxt;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] cnt, hi_w, cand, cand_nxt, period_nxt;
  logic [3:0]       mcnt, mcnt_nxt, new_m;
  logic             rise, fall, qual, timeout;
  logic             div4_nxt, locked_nxt, err_nxt;

  always_ff @(posedge clkin or negedge rstb) begin
    if (!rstb) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= divclk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  always_ff @(posedge clkin or negedge rstb) begin
    if (!rstb) begin
      cnt  <= '0;
      hi_w <= '0;
    end else begin
      if (rise)
        cnt <= CNT_W'(1);
      else if (cnt != MAX)
        cnt <= cnt + CNT_W'(1);
      if (fall)
        hi_w <= cnt;
    end
  end

  // cnt still holds the pre-reload count on a rise cycle, so it is the measured period.
  assign qual    = (cnt >= P2) && (cnt != MAX) && ({hi_w, 1'b0} == {1'b0, cnt});
  assign timeout = ~rise && (cnt == MAX);
  assign new_m   = ((mcnt != 4'd0) && (cnt == cand)) ? mcnt + 4'd1 : 4'd1;

  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    mcnt_nxt   = mcnt;
    period_nxt = period;
    div4_nxt   = div4not2;
    locked_nxt = locked;
    err_nxt    = 1'b0;
    case (state)
      ST_SEED: begin
        if (rise) begin
          state_nxt = ST_HUNT;
          mcnt_nxt  = 4'd0;
        end
      end
      ST_HUNT: begin
        if (rise) begin
          if (!qual) begin
            mcnt_nxt = 4'd0;
          end else begin
            cand_nxt = cnt;
            mcnt_nxt = new_m;
            if (new_m == LOCK_M) begin
              state_nxt  = ST_LOCKED;
              period_nxt = cnt;
              div4_nxt   = (cnt == P4);
              locked_nxt = 1'b1;
            end
          end
        end else if (timeout) begin
          state_nxt = ST_SEED;
          err_nxt   = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (rise) begin
          if (!(qual && (cnt == period))) begin
            state_nxt  = ST_HUNT;
            err_nxt    = 1'b1;
            period_nxt = '0;
            div4_nxt   = 1'b0;
            locked_nxt = 1'b0;
            cand_nxt   = qual ? cnt : cand;
            mcnt_nxt   = qual ? 4'd1 : 4'd0;
          end
        end else if (timeout) begin
          state_nxt  = ST_SEED;
          err_nxt    = 1'b1;
          period_nxt = '0;
          div4_nxt   = 1'b0;
          locked_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt  = ST_SEED;
        period_nxt = '0;
        div4_nxt   = 1'b0;
        locked_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clkin or negedge rstb) begin
    if (!rstb) begin
      state    <= ST_SEED;
      cand     <= '0;
      mcnt     <= 4'd0;
      period   <= '0;
      div4not2 <= 1'b0;
      locked   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cand     <= cand_nxt;
      mcnt     <= mcnt_nxt;
      period   <= period_nxt;
      div4not2 <= div4_nxt;
      locked   <= locked_nxt;
      err      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_clkratio_det.sv
// Directed bench for clkratio_det: wave-pattern table plus cycle-exact lock, unlock and reset sequences.
module tb_clkratio_det;

  logic       clkin;
  logic       rstb;
  logic       divclk;
  logic [3:0] period;
  logic       div4not2;
  logic       locked;
  logic       err;

  int checks     = 0;
  int errors     = 0;
  int errs_seen  = 0;
  logic prev_err = 1'b0;

  clkratio_det #(.CNT_W(4), .LOCK_COUNT(4)) dut (
    .clkin   (clkin),
    .rstb    (rstb),
    .divclk  (divclk),
    .period  (period),
    .div4not2(div4not2),
    .locked  (locked),
    .err     (err)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  typedef struct {
    bit         rst;
    int         hi;
    int         lo;
    int         n;
    bit         exp_locked;
    logic [3:0] exp_period;
    bit         exp_div4;
    int         exp_errs;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input logic d);
    divclk = d;
    @(posedge clkin);
    #1;
    checks++;
    if (err && prev_err) begin
      errors++;
      $display("FAIL err_width: err high on two consecutive cycles at %0t", $time);
    end
    prev_err = err;
    if (err) errs_seen++;
  endtask

  task automatic check_outs(input string tag, input int l, input int p, input int d4, input int e);
    chk({tag, "_locked"}, int'(locked), l);
    chk({tag, "_period"}, int'(period), p);
    chk({tag, "_div4"}, int'(div4not2), d4);
    chk({tag, "_err"}, int'(err), e);
  endtask

  task automatic do_reset();
    rstb   = 1'b0;
    divclk = 1'b0;
    repeat (2) @(posedge clkin);
    #1;
    check_outs("reset", 0, 0, 0, 0);
    rstb     = 1'b1;
    prev_err = 1'b0;
  endtask

  initial begin
    // {rst, hi, lo, periods, locked, period, div4, err pulses}
    vecs[0]  = '{1'b1, 1, 1,  8, 1'b1, 4'd2, 1'b0, 0}; // /2 from reset
    vecs[1]  = '{1'b1, 2, 2,  8, 1'b1, 4'd4, 1'b1, 0}; // /4 from reset
    vecs[2]  = '{1'b0, 1, 1,  8, 1'b1, 4'd2, 1'b0, 1}; // switch to /2, relock
    vecs[3]  = '{1'b1, 1, 3,  8, 1'b0, 4'd0, 1'b0, 0}; // asymmetric never locks
    vecs[4]  = '{1'b1, 2, 2,  8, 1'b1, 4'd4, 1'b1, 0};
    vecs[5]  = '{1'b0, 20, 0, 1, 1'b0, 4'd0, 1'b0, 1}; // stalled high -> timeout
    vecs[6]  = '{1'b0, 2, 2,  8, 1'b1, 4'd4, 1'b1, 0}; // restart /4 from SEED
    vecs[7]  = '{1'b1, 1, 1,  8, 1'b1, 4'd2, 1'b0, 0};
    vecs[8]  = '{1'b0, 2, 1,  1, 1'b1, 4'd2, 1'b0, 0}; // stretched high phase
    vecs[9]  = '{1'b0, 1, 1,  5, 1'b0, 4'd0, 1'b0, 1}; // glitch detected, 3 good rises
    vecs[10] = '{1'b0, 1, 1,  1, 1'b1, 4'd2, 1'b0, 0}; // 4th good rise relocks

    rstb   = 1'b1;
    divclk = 1'b0;
    #2;
    do_reset();

    // /4 from reset: seed rise lands at edge 2, lock visible from edge 18.
    errs_seen = 0;
    for (int e = 0; e < 24; e++) begin
      tick((e % 4) < 2);
      chk($sformatf("lock4_e%0d", e), int'(locked), (e >= 18) ? 1 : 0);
    end
    check_outs("lock4_end", 1, 4, 1, 0);
    chk("lock4_errs", errs_seen, 0);

    // Switch to /2: first /2 rise closes a good /4 period, the next one mismatches.
    for (int k = 0; k < 6; k++) begin
      tick((k % 2) == 0);
      if (k == 3) check_outs("sw_k3", 1, 4, 1, 0);
      if (k == 4) check_outs("sw_k4", 0, 0, 0, 1);
      if (k == 5) chk("sw_k5_err", int'(err), 0);
    end

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst) do_reset();
      errs_seen = 0;
      for (int p = 0; p < vecs[i].n; p++) begin
        for (int h = 0; h < vecs[i].hi; h++) tick(1'b1);
        for (int l = 0; l < vecs[i].lo; l++) tick(1'b0);
      end
      chk($sformatf("v%0d_locked", i), int'(locked), int'(vecs[i].exp_locked));
      chk($sformatf("v%0d_period", i), int'(period), int'(vecs[i].exp_period));
      chk($sformatf("v%0d_div4", i), int'(div4not2), int'(vecs[i].exp_div4));
      chk($sformatf("v%0d_errs", i), errs_seen, vecs[i].exp_errs);
    end

    // Asynchronous reset mid-cycle while locked at /2.
    chk("pre_arst_locked", int'(locked), 1);
    #3;
    rstb = 1'b0;
    #1;
    check_outs("arst", 0, 0, 0, 0);
    divclk = 1'b0;
    @(posedge clkin);
    #1;
    rstb     = 1'b1;
    prev_err = 1'b0;

    // /2 after release: seed rise at edge 2, lock visible from edge 10.
    errs_seen = 0;
    for (int e = 0; e < 14; e++) begin
      tick((e % 2) == 0);
      chk($sformatf("lock2_e%0d", e), int'(locked), (e >= 10) ? 1 : 0);
    end
    check_outs("lock2_end", 1, 2, 0, 0);
    chk("lock2_errs", errs_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
